axi_ar_route_decoder: RTL
=========================

# axi_ar_route_decoder

Read-address front end of one target port of the AXI node. It decodes each incoming AR request against a per-initiator address map and forwards the request to exactly one initiator port. Unmapped requests are accepted and turned into an error-response request toward the read-response allocator of the same target port. It also drives that allocator's outstanding-transaction increment and its error bookkeeping inputs.

## Interface
- N_INIT_PORT, 7: number of initiator (downstream) ports.
- AXI_ADDR_W, 32: address width.
- AXI_ID_IN, 16: ID width on the target port.
- AXI_USER_W, 6: user width.
- LOG_N_INIT, $clog2(N_INIT_PORT): index width.

- clk  in  1: clock. One clock domain.
- rst  in  1: synchronous, active-high reset.
- arvalid_i / arready_o  in / out  1 / 1: target-side AR handshake.
- araddr_i  in  AXI_ADDR_W: request address.
- arid_i  in  AXI_ID_IN: request ID.
- arlen_i  in  8: request burst length.
- aruser_i  in  AXI_USER_W: request user field.
- arvalid_o  out  N_INIT_PORT: one-hot request toward the initiator ports.
- arready_i  in  N_INIT_PORT: ready from the initiator ports.
- start_addr_i, end_addr_i  in  N_INIT_PORT×AXI_ADDR_W: inclusive address region per port.
- connectivity_map_i  in  N_INIT_PORT: per-port enable.
- incr_req_o  out  1: one-cycle pulse per routed AR handshake.
- full_counter_i  in  1: allocator outstanding counter is saturated.
- error_req_o  out  1: error response request.
- error_gnt_i  in  1: error response completed.
- error_len_o  out  8: burst length of the error response.
- error_id_o  out  AXI_ID_IN: ID of the error response.
- error_user_o  out  AXI_USER_W: user field of the error response.
- sample_ardata_info_o  out  1: strobe telling the allocator to capture the error fields.
- err_count_o  out  16: saturating count of decode errors.

## Operation
- Match vector: match[k] = connectivity_map_i[k] & (araddr_i ≥ start_addr_i[k]) & (araddr_i ≤ end_addr_i[k]). Comparisons are unsigned.
- Multiple matches: the lowest index wins. No match: decode error.
- FSM states: OPERATIVE, ERR_ISSUE, ERR_WAIT.
- OPERATIVE with arvalid_i=1 and full_counter_i=0:
  - Routed request: arvalid_o = onehot(sel) and arready_o = arready_i[sel].
  - On handshake: incr_req_o=1 for that cycle.
  - Unmapped request: arready_o=1 (accept). Register arlen_i, arid_i and aruser_i into error_len_o, error_id_o and error_user_o. Go to ERR_ISSUE.
- OPERATIVE with full_counter_i=1: arready_o=0 and arvalid_o=0. The request is held and nothing is forwarded.
- ERR_ISSUE, exactly one cycle: error_req_o=1, sample_ardata_info_o=1, arready_o=0. Go to ERR_WAIT.
- ERR_WAIT: error_req_o=1, arready_o=0, arvalid_o=0. When error_gnt_i=1, go to OPERATIVE; error_req_o is low from the next cycle.
- error_gnt_i in OPERATIVE or ERR_ISSUE is ignored.
- err_count_o increments on every unmapped acceptance and saturates at 16'hFFFF.
- error_* output registers hold their value until the next unmapped acceptance.

## Timing
- Reset values:
  - FSM state: OPERATIVE.
  - error_len_o, error_id_o, error_user_o: 0.
  - err_count_o: 0.
  - All strobes, arvalid_o and arready_o: 0 while rst=1.
- Routed path is combinational: arvalid_i → arvalid_o and arready_i → arready_o, zero added latency.
- Error path:
  - Acceptance at cycle T.
  - error_req_o rises at T+1, together with the one-cycle sample_ardata_info_o.
  - error_req_o stays high through the cycle in which error_gnt_i=1, and is low in the following cycle.
- No AR is accepted from T+1 until the cycle after error_gnt_i. This keeps error and routed responses in order.
- Simultaneous unmapped arvalid_i and full_counter_i=1: not accepted. Errors also wait for a non-full counter.
- AXI stability rule: once arvalid_o[k] is asserted, the decoded port does not change until the handshake. This holds because araddr_i is required stable while arvalid_i is high.
- Reset mid-error: state returns to OPERATIVE and error_req_o drops the next cycle. The allocator is reset by the same rst.

## Structure
- Shared package axi_node_pkg holds:
  - the FSM enum typedef (ar_dec_state_t);
  - the error counter width constant.
- DECERR and the DEADBEEF payload stay in the existing defines.
- One sub-module, axi_address_match: purely combinational; contains the per-port comparators and the lowest-index priority encoder; outputs sel (LOG_N_INIT bits) and a miss flag.

## Test plan
- Routed request: port 2 region 0x1000–0x1FFF; AR at 0x1800 with arready_i[2] stalled 3 cycles → arvalid_o=7'b0000100 held 3 cycles; a single incr_req_o pulse on the handshake.
- Overlapping regions: ports 1 and 4 both match 0x2000 → routed to port 1 only.
- Unmapped single beat: AR at 0xF000_0000, arlen=0, id=0x5A → one-cycle arready_o; next cycle error_req_o=1, sample pulse, error_len_o=0, error_id_o=0x5A; error_gnt_i after 4 cycles → req low the next cycle; err_count_o=1.
- Back-to-back while in error: a second valid AR arriving during ERR_WAIT → arready_o stays 0 until the cycle after error_gnt_i, then the AR is routed normally.
- full_counter_i=1 with a valid mapped AR → arvalid_o=0 and no incr_req_o; release full_counter_i → forwarded the same cycle.
- Reset: assert rst in ERR_WAIT → all outputs 0 the next cycle, err_count_o=0; a new AR after reset is decoded normally.

Source files
------------

// File: rtl/axi_node_pkg.sv
// Shared types and constants for the AXI node read-address path.
package axi_node_pkg;

   typedef enum logic [1:0] {
      OPERATIVE = 2'd0,
      ERR_ISSUE = 2'd1,
      ERR_WAIT  = 2'd2
   } ar_dec_state_t;

   localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/axi_address_match.sv
// Per-port region comparators plus a lowest-index priority encoder.
module axi_address_match #(
   parameter int N_INIT_PORT = 7,
   parameter int AXI_ADDR_W  = 32,
   parameter int LOG_N_INIT  = $clog2(N_INIT_PORT)
) (
   input  logic [AXI_ADDR_W-1:0]                  addr,
   input  logic [N_INIT_PORT-1:0][AXI_ADDR_W-1:0] start_addr,
   input  logic [N_INIT_PORT-1:0][AXI_ADDR_W-1:0] end_addr,
   input  logic [N_INIT_PORT-1:0]                 connectivity_map,
   output logic [LOG_N_INIT-1:0]                  sel,
   output logic                                   miss
);

   logic [N_INIT_PORT-1:0] match;

   genvar k;
   generate
      for (k = 0; k < N_INIT_PORT; k++) begin : g_cmp
         assign match[k] = connectivity_map[k] &
                           (addr >= start_addr[k]) &
                           (addr <= end_addr[k]);
      end
   endgenerate

   // Scan downward so the lowest matching index is the last one written.
   always_comb begin
      sel = '0;
      for (int i = N_INIT_PORT - 1; i >= 0; i--) begin
         if (match[i]) sel = LOG_N_INIT'(i);
      end
   end

   assign miss = ~|match;

endmodule

// File: rtl/axi_ar_route_decoder.sv
// AR front end of one target port: routes mapped requests, turns unmapped ones into error requests.
module axi_ar_route_decoder
   import axi_node_pkg::*;
#(
   parameter int N_INIT_PORT = 7,
   parameter int AXI_ADDR_W  = 32,
   parameter int AXI_ID_IN   = 16,
   parameter int AXI_USER_W  = 6,
   parameter int LOG_N_INIT  = $clog2(N_INIT_PORT)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   arvalid_i,
   output logic                                   arready_o,
   input  logic [AXI_ADDR_W-1:0]                  araddr_i,
   input  logic [AXI_ID_IN-1:0]                   arid_i,
   input  logic [7:0]                             arlen_i,
   input  logic [AXI_USER_W-1:0]                  aruser_i,
   output logic [N_INIT_PORT-1:0]                 arvalid_o,
   input  logic [N_INIT_PORT-1:0]                 arready_i,
   input  logic [N_INIT_PORT-1:0][AXI_ADDR_W-1:0] start_addr_i,
   input  logic [N_INIT_PORT-1:0][AXI_ADDR_W-1:0] end_addr_i,
   input  logic [N_INIT_PORT-1:0]                 connectivity_map_i,
   output logic                                   incr_req_o,
   input  logic                                   full_counter_i,
   output logic                                   error_req_o,
   input  logic                                   error_gnt_i,
   output logic [7:0]                             error_len_o,
   output logic [AXI_ID_IN-1:0]                   error_id_o,
   output logic [AXI_USER_W-1:0]                  error_user_o,
   output logic                                   sample_ardata_info_o,
   output logic [ERR_CNT_W-1:0]                   err_count_o
);

   ar_dec_state_t          state, state_nxt;
   logic [LOG_N_INIT-1:0]  sel;
   logic                   miss;
   logic                   err_accept;

   axi_address_match #(
      .N_INIT_PORT (N_INIT_PORT),
      .AXI_ADDR_W  (AXI_ADDR_W),
      .LOG_N_INIT  (LOG_N_INIT)
   ) u_match (
      .addr             (araddr_i),
      .start_addr       (start_addr_i),
      .end_addr         (end_addr_i),
      .connectivity_map (connectivity_map_i),
      .sel              (sel),
      .miss             (miss)
   );

   always_comb begin
      state_nxt            = state;
      arvalid_o            = '0;
      arready_o            = 1'b0;
      incr_req_o           = 1'b0;
      error_req_o          = 1'b0;
      sample_ardata_info_o = 1'b0;
      err_accept           = 1'b0;
      case (state)
         OPERATIVE: begin
            // A saturated outstanding counter blocks both routed and error requests.
            if (arvalid_i && !full_counter_i) begin
               if (miss) begin
                  arready_o  = 1'b1;
                  err_accept = 1'b1;
                  state_nxt  = ERR_ISSUE;
               end else begin
                  arvalid_o  = {{(N_INIT_PORT-1){1'b0}}, 1'b1} << sel;
                  arready_o  = arready_i[sel];
                  incr_req_o = arready_i[sel];
               end
            end
         end
         ERR_ISSUE: begin
            error_req_o          = 1'b1;
            sample_ardata_info_o = 1'b1;
            state_nxt            = ERR_WAIT;
         end
         ERR_WAIT: begin
            error_req_o = 1'b1;
            if (error_gnt_i) state_nxt = OPERATIVE;
         end
         default: state_nxt = OPERATIVE;
      endcase
      if (rst) begin
         arvalid_o            = '0;
         arready_o            = 1'b0;
         incr_req_o           = 1'b0;
         error_req_o          = 1'b0;
         sample_ardata_info_o = 1'b0;
         err_accept           = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= OPERATIVE;
         error_len_o  <= '0;
         error_id_o   <= '0;
         error_user_o <= '0;
         err_count_o  <= '0;
      end else begin
         state <= state_nxt;
         if (err_accept) begin
            error_len_o  <= arlen_i;
            error_id_o   <= arid_i;
            error_user_o <= aruser_i;
            if (err_count_o != {ERR_CNT_W{1'b1}}) err_count_o <= err_count_o + 1'b1;
         end
      end
   end

endmodule
